// File: rtl/pipo_pkg.sv
// Shared definitions for the parallel-in, parallel-out register family.
// Holds the default word width, the word type and the default reset value.
package pipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] pipo_word_t;

    localparam pipo_word_t DEFAULT_RESET_VALUE = '0;

endpackage : pipo_pkg

// File: rtl/pipo_stage.sv
// One WIDTH-bit register stage with a synchronous, active-high reset to RESET_VALUE.
// The top level chains these stages to build a retiming pipeline.
module pipo_stage
    import pipo_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule : pipo_stage

// File: rtl/pipo_register.sv
// Parallel-in, parallel-out register with STAGES chained register stages.
// The output comes straight from the last stage's flops, so no input reaches it combinationally.
module pipo_register
    import pipo_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out
);

    generate
        if (WIDTH < 1 || STAGES < 1) begin : g_param_check
            $error("pipo_register: WIDTH and STAGES must both be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] stage_q [STAGES];

    // Stage 0 captures the input; every later stage takes its predecessor's output.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                pipo_stage #(
                    .WIDTH       (WIDTH),
                    .RESET_VALUE (RESET_VALUE)
                ) u_stage (
                    .clk (clk),
                    .rst (rst),
                    .d   (parallel_in),
                    .q   (stage_q[k])
                );
            end else begin : g_chain
                pipo_stage #(
                    .WIDTH       (WIDTH),
                    .RESET_VALUE (RESET_VALUE)
                ) u_stage (
                    .clk (clk),
                    .rst (rst),
                    .d   (stage_q[k-1]),
                    .q   (stage_q[k])
                );
            end
        end
    endgenerate

    assign parallel_out = stage_q[STAGES-1];

endmodule : pipo_register

// File: tb/tb_pipo_register.sv
// Self-checking bench for pipo_register: a default 4-bit single-stage instance and
// an 8-bit, three-stage instance with a non-zero reset value, both fed each cycle.
module tb_pipo_register;
    import pipo_pkg::*;

    localparam int         P_WIDTH  = 8;
    localparam int         P_STAGES = 3;
    localparam logic [7:0] P_RESET  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    pipo_word_t din_a;
    pipo_word_t dout_a;
    logic [7:0] din_b;
    logic [7:0] dout_b;

    int compared   = 0;
    int mismatched = 0;
    bit model_valid = 1'b0;

    // In-flight words per instance; the back entry is what the output should show.
    pipo_word_t q_a [$];
    logic [7:0] q_b [$];

    always #5 clk = ~clk;

    pipo_register dut_a (
        .clk          (clk),
        .rst          (rst),
        .parallel_in  (din_a),
        .parallel_out (dout_a)
    );

    pipo_register #(
        .WIDTH       (P_WIDTH),
        .STAGES      (P_STAGES),
        .RESET_VALUE (P_RESET)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .parallel_in  (din_b),
        .parallel_out (dout_b)
    );

    task automatic model_edge(input logic r, input pipo_word_t a, input logic [7:0] b);
        if (r) begin
            foreach (q_a[i]) q_a[i] = DEFAULT_RESET_VALUE;
            foreach (q_b[i]) q_b[i] = P_RESET;
            model_valid = 1'b1;
        end else begin
            q_a.push_front(a);
            void'(q_a.pop_back());
            q_b.push_front(b);
            void'(q_b.pop_back());
        end
    endtask

    task automatic step(input logic r, input pipo_word_t a, input logic [7:0] b, input string tag);
        pipo_word_t exp_a;
        logic [7:0] exp_b;
        @(negedge clk);
        rst   = r;
        din_a = a;
        din_b = b;
        #1;
        if (model_valid) begin
            exp_a = q_a[$];
            exp_b = q_b[$];
            compared++;
            if (dout_a !== exp_a) begin
                mismatched++;
                $display("[TB] FAIL %s hold_a: got %b expected %b", tag, dout_a, exp_a);
            end
            compared++;
            if (dout_b !== exp_b) begin
                mismatched++;
                $display("[TB] FAIL %s hold_b: got %h expected %h", tag, dout_b, exp_b);
            end
        end
        model_edge(r, a, b);
        @(posedge clk);
        #1;
        exp_a = q_a[$];
        exp_b = q_b[$];
        compared++;
        if (dout_a !== exp_a) begin
            mismatched++;
            $display("[TB] FAIL %s out_a: got %b expected %b", tag, dout_a, exp_a);
        end
        compared++;
        if (dout_b !== exp_b) begin
            mismatched++;
            $display("[TB] FAIL %s out_b: got %h expected %h", tag, dout_b, exp_b);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        step(1'b1, 4'b0000, 8'h00, "reset");
        compared++;
        if (dout_a !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_const_a: got %b expected 0000", dout_a);
        end
        compared++;
        if (dout_b !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL reset_const_b: got %h expected a5", dout_b);
        end
    endtask

    task automatic test_sequence();
        pipo_word_t seq [3];
        seq = '{4'b1010, 4'b1101, 4'b0111};
        $display("[TB] test_sequence");
        foreach (seq[i]) begin
            step(1'b0, seq[i], {4'h0, seq[i]}, "sequence");
            compared++;
            if (dout_a !== seq[i]) begin
                mismatched++;
                $display("[TB] FAIL sequence_const: got %b expected %b", dout_a, seq[i]);
            end
        end
    endtask

    task automatic test_midstream_reset();
        $display("[TB] test_midstream_reset");
        step(1'b0, 4'b1111, 8'hFF, "mid_pre");
        step(1'b1, 4'b1111, 8'hFF, "mid_rst");
        step(1'b0, 4'b1111, 8'hFF, "mid_post");
        step(1'b0, 4'b1111, 8'hFF, "mid_post");
        step(1'b0, 4'b1111, 8'hFF, "mid_post");
    endtask

    task automatic test_reset_wins();
        $display("[TB] test_reset_wins");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, (i % 2) ? 4'b1010 : 4'b0101, (i % 2) ? 8'hAA : 8'h55, "reset_wins");
        end
    endtask

    task automatic test_glitch();
        $display("[TB] test_glitch");
        step(1'b0, 4'b0011, 8'h33, "glitch_setup");
        @(negedge clk);
        rst   = 1'b0;
        din_a = 4'b0011;
        din_b = 8'h33;
        #1;
        din_a = 4'b1100;
        din_b = 8'hCC;
        #2;
        compared++;
        if (dout_a !== q_a[$]) begin
            mismatched++;
            $display("[TB] FAIL glitch_hold_a: got %b expected %b", dout_a, q_a[$]);
        end
        compared++;
        if (dout_b !== q_b[$]) begin
            mismatched++;
            $display("[TB] FAIL glitch_hold_b: got %h expected %h", dout_b, q_b[$]);
        end
        din_a = 4'b0011;
        din_b = 8'h33;
        model_edge(1'b0, 4'b0011, 8'h33);
        @(posedge clk);
        #1;
        compared++;
        if (dout_a !== 4'b0011) begin
            mismatched++;
            $display("[TB] FAIL glitch_out_a: got %b expected 0011", dout_a);
        end
        compared++;
        if (dout_b !== q_b[$]) begin
            mismatched++;
            $display("[TB] FAIL glitch_out_b: got %h expected %h", dout_b, q_b[$]);
        end
    endtask

    task automatic test_pipeline();
        $display("[TB] test_pipeline");
        step(1'b1, 4'b0000, 8'h00, "pipe_rst");
        step(1'b0, 4'b0001, 8'h12, "pipe_n");
        compared++;
        if (dout_b !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL pipe_n_const: got %h expected a5", dout_b);
        end
        step(1'b0, 4'b0010, 8'h34, "pipe_n1");
        compared++;
        if (dout_b !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL pipe_n1_const: got %h expected a5", dout_b);
        end
        step(1'b0, 4'b0011, 8'h56, "pipe_n2");
        compared++;
        if (dout_b !== 8'h12) begin
            mismatched++;
            $display("[TB] FAIL pipe_n2_const: got %h expected 12", dout_b);
        end
    endtask

    task automatic test_back_to_back();
        logic r;
        $display("[TB] test_back_to_back");
        for (int i = 0; i < 24; i++) begin
            r = ($urandom_range(0, 7) == 0);
            step(r, 4'($urandom), 8'($urandom), "back_to_back");
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        din_a = '0;
        din_b = '0;
        q_a.push_back('x);
        for (int i = 0; i < P_STAGES; i++) q_b.push_back('x);
        test_reset();
        test_sequence();
        test_midstream_reset();
        test_reset_wins();
        test_glitch();
        test_pipeline();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_pipo_register
